// File: rtl/pipeline_broadcast_fifo_if.sv
// Producer and N-consumer handshake bundle for pipeline_broadcast_fifo.
// slave = the fifo block, master = the surrounding producer/consumers.
interface pipeline_broadcast_fifo_if #(
   parameter int N     = 2,
   parameter int W     = 32,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                   i_valid;
   logic                   i_ready;
   logic [W-1:0]           i_data;
   logic [N-1:0]           i_mask;
   logic [N-1:0]           o_valid;
   logic [N-1:0]           o_ready;
   logic [N-1:0][W-1:0]    o_data;
   logic [N-1:0][CW-1:0]   o_count;

   modport master (
      output i_valid, i_data, i_mask, o_ready,
      input  i_ready, o_valid, o_data, o_count
   );

   modport slave (
      input  i_valid, i_data, i_mask, o_ready,
      output i_ready, o_valid, o_data, o_count
   );
endinterface

// File: rtl/pipeline_broadcast_fifo.sv
// Masked broadcast of one producer into N per-channel DEPTH-entry FIFOs; entries visible 1 cycle after accept.
// Backpressure: i_ready drops only when a masked channel is full (registered), never from o_ready.
module pipeline_broadcast_fifo #(
   parameter int N     = 2,
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input logic                      clk,
   input logic                      rst_n,
   pipeline_broadcast_fifo_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [N-1:0] full;
   logic         accept;

   // Registered full flags only, so a same-cycle pop never frees a slot for the producer.
   assign bus.i_ready = &(~bus.i_mask | ~full);
   assign accept      = bus.i_valid & bus.i_ready;

   for (genvar g = 0; g < N; g++) begin : g_ch
      logic [W-1:0]  mem [DEPTH];
      logic [PW-1:0] wr_ptr;
      logic [PW-1:0] rd_ptr;
      logic [CW-1:0] count;
      logic          vld;
      logic          push;
      logic          pop;

      assign push    = accept & bus.i_mask[g];
      assign pop     = vld & bus.o_ready[g];
      assign full[g] = (count == CW'(DEPTH));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
               mem[k] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= 1'b0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= bus.i_data;
               wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
               2'b10: begin
                  count <= count + CW'(1);
                  vld   <= 1'b1;
               end
               2'b01: begin
                  count <= count - CW'(1);
                  vld   <= (count != CW'(1));
               end
               default: ;
            endcase
         end
      end

      assign bus.o_data[g]  = mem[rd_ptr];
      assign bus.o_valid[g] = vld;
      assign bus.o_count[g] = count;
   end
endmodule

// File: tb/tb_pipeline_broadcast_fifo.sv
// Scoreboard bench: per-channel expected-data queues model each FIFO; two instances (N=2/DEPTH=2, N=3/DEPTH=1).
module tb_pipeline_broadcast_fifo;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pipeline_broadcast_fifo_if #(.N(2), .W(32), .DEPTH(2)) ifa();
   pipeline_broadcast_fifo_if #(.N(3), .W(32), .DEPTH(1)) ifb();

   pipeline_broadcast_fifo #(.N(2), .W(32), .DEPTH(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   pipeline_broadcast_fifo #(.N(3), .W(32), .DEPTH(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   int checks = 0;
   int errors = 0;
   int b_acc  = 0;
   int w;
   bit ra, rb;
   // Channels 0-1 belong to instance A, 2-4 to instance B.
   logic [31:0] q [5][$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_ready(input int base, input int n, input int depth, input logic [2:0] mask);
      for (int i = 0; i < n; i++)
         if (mask[i] && q[base + i].size() >= depth) return 1'b0;
      return 1'b1;
   endfunction

   task automatic chan_step(input int idx, input int depth, input logic vld, input logic rdy,
                            input logic [31:0] dat, input int cnt, input bit push, input logic [31:0] pdat);
      int sz = q[idx].size();
      check($sformatf("valid_ch%0d", idx), 32'(vld), 32'(sz > 0));
      check($sformatf("count_ch%0d", idx), 32'(cnt), 32'(sz));
      check($sformatf("count_range_ch%0d", idx), 32'(cnt <= depth), 32'd1);
      if (sz > 0) begin
         check($sformatf("data_ch%0d", idx), dat, q[idx][0]);
         if (rdy) void'(q[idx].pop_front());
      end
      if (push) q[idx].push_back(pdat);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) q[i].delete();
         check("rst_a_valid", 32'(ifa.o_valid), 32'd0);
         check("rst_a_count", 32'(ifa.o_count), 32'd0);
         check("rst_a_data", ifa.o_data[0] | ifa.o_data[1], 32'd0);
         check("rst_b_valid", 32'(ifb.o_valid), 32'd0);
         check("rst_b_data", ifb.o_data[0] | ifb.o_data[1] | ifb.o_data[2], 32'd0);
      end else begin
         ra = model_ready(0, 2, 2, {1'b0, ifa.i_mask});
         check("a_i_ready", 32'(ifa.i_ready), 32'(ra));
         for (int c = 0; c < 2; c++)
            chan_step(c, 2, ifa.o_valid[c], ifa.o_ready[c], ifa.o_data[c], int'(ifa.o_count[c]),
                      ifa.i_valid && ra && ifa.i_mask[c], ifa.i_data);
         rb = model_ready(2, 3, 1, ifb.i_mask);
         check("b_i_ready", 32'(ifb.i_ready), 32'(rb));
         for (int c = 0; c < 3; c++)
            chan_step(2 + c, 1, ifb.o_valid[c], ifb.o_ready[c], ifb.o_data[c], int'(ifb.o_count[c]),
                      ifb.i_valid && rb && ifb.i_mask[c], ifb.i_data);
         if (ifb.i_valid && rb) b_acc++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      ifa.i_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Holds the transaction until accepted or limit cycles pass; returns the stall count.
   task automatic push_a(input logic [31:0] d, input logic [1:0] m, input int limit, output int waited);
      ifa.i_valid = 1'b1;
      ifa.i_data  = d;
      ifa.i_mask  = m;
      waited      = 0;
      @(negedge clk);
      while (!ifa.i_ready && waited < limit) begin
         waited++;
         @(negedge clk);
      end
      check("a_push_accepted", 32'(ifa.i_ready), 32'd1);
      tick();
      ifa.i_valid = 1'b0;
   endtask

   initial begin
      ifa.i_valid = 1'b0; ifa.i_data = '0; ifa.i_mask = '0; ifa.o_ready = 2'b11;
      ifb.i_valid = 1'b0; ifb.i_data = '0; ifb.i_mask = '0; ifb.o_ready = 3'b111;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_a_i_ready", 32'(ifa.i_ready), 32'd1);
      #2 rst_n = 1'b1;
      tick();

      // Back-to-back broadcast
      for (int i = 1; i <= 4; i++) begin
         push_a(32'hA5A5_0000 + 32'(i), 2'b11, 4, w);
         check("bcast_stall", 32'(w), 32'd0);
      end
      idle(4);

      // Slow consumer on channel 1
      ifa.o_ready = 2'b01;
      push_a(32'h5100_0001, 2'b11, 2, w); check("slow_w1_stall", 32'(w), 32'd0);
      push_a(32'h5100_0002, 2'b11, 2, w); check("slow_w2_stall", 32'(w), 32'd0);
      ifa.i_valid = 1'b1; ifa.i_data = 32'h5100_0003; ifa.i_mask = 2'b11;
      repeat (3) begin
         @(negedge clk);
         check("slow_blocked", 32'(ifa.i_ready), 32'd0);
      end
      check("slow_cnt1", 32'(ifa.o_count[1]), 32'd2);
      check("slow_cnt0", 32'(ifa.o_count[0]), 32'd0);
      tick();
      ifa.o_ready = 2'b11;
      @(negedge clk); check("slow_pop_cycle_blocked", 32'(ifa.i_ready), 32'd0);
      @(negedge clk); check("slow_accept_after_pop", 32'(ifa.i_ready), 32'd1);
      tick();
      idle(4);

      // Masked routing, including an all-zero mask that is dropped
      push_a(32'h11, 2'b01, 2, w); check("route_11", 32'(w), 32'd0);
      push_a(32'h22, 2'b10, 2, w); check("route_22", 32'(w), 32'd0);
      push_a(32'h33, 2'b11, 2, w); check("route_33", 32'(w), 32'd0);
      push_a(32'h44, 2'b00, 2, w); check("route_44", 32'(w), 32'd0);
      idle(4);

      // Full channel 1 bypassed by a mask that avoids it
      ifa.o_ready = 2'b01;
      push_a(32'hAA, 2'b10, 2, w);
      push_a(32'hBB, 2'b10, 2, w);
      push_a(32'h55, 2'b01, 2, w); check("bypass_stall", 32'(w), 32'd0);
      ifa.i_valid = 1'b1; ifa.i_data = 32'h66; ifa.i_mask = 2'b11;
      @(negedge clk); check("bypass_full_blocks", 32'(ifa.i_ready), 32'd0);
      tick();
      ifa.o_ready = 2'b11;
      idle(5);

      // DEPTH=1 instance: continuous traffic accepted every other cycle
      ifb.o_ready = 3'b111; ifb.i_mask = 3'b111; ifb.i_valid = 1'b1;
      b_acc = 0;
      for (int i = 0; i < 100; i++) begin
         ifb.i_data = 32'hB000_0000 + 32'(i);
         tick();
      end
      ifb.i_valid = 1'b0;
      check("depth1_accept_rate", 32'(b_acc), 32'd50);
      idle(3);

      // Asynchronous reset while both channels hold 2 entries
      ifa.o_ready = 2'b00;
      push_a(32'hC000_0001, 2'b11, 2, w);
      push_a(32'hC000_0002, 2'b11, 2, w);
      check("pre_rst_count", 32'(ifa.o_count), {28'd0, 2'd2, 2'd2});
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(ifa.o_valid), 32'd0);
      check("async_rst_count", 32'(ifa.o_count), 32'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      tick();
      ifa.o_ready = 2'b11;
      push_a(32'hDEAD_BEEF, 2'b11, 2, w); check("post_rst_stall", 32'(w), 32'd0);
      idle(4);

      // Randomised traffic on both instances
      for (int i = 0; i < 1500; i++) begin
         ifa.i_valid = 1'($urandom_range(0, 1));
         ifa.i_data  = $urandom;
         ifa.i_mask  = 2'($urandom_range(0, 3));
         ifa.o_ready = 2'($urandom_range(0, 3));
         ifb.i_valid = 1'($urandom_range(0, 1));
         ifb.i_data  = $urandom;
         ifb.i_mask  = 3'($urandom_range(0, 7));
         ifb.o_ready = 3'($urandom_range(0, 7));
         tick();
      end
      ifb.i_valid = 1'b0; ifb.o_ready = 3'b111;
      ifa.o_ready = 2'b11;
      idle(8);
      check("drained_a", 32'(ifa.o_valid), 32'd0);
      check("drained_b", 32'(ifb.o_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
